// File: rtl/pulse_param_rx_pkg.sv
// Shared constants for the pulse-parameter UART link: frame header, address map,
// parser/receiver state encodings and power-on register defaults.
package pulse_param_rx_pkg;

    localparam logic [7:0] FRAME_HEADER = 8'hAA;

    localparam logic [7:0] ADDR_PER   = 8'd0;
    localparam logic [7:0] ADDR_P1WID = 8'd1;
    localparam logic [7:0] ADDR_DEL   = 8'd2;
    localparam logic [7:0] ADDR_P2WID = 8'd3;
    localparam logic [7:0] ADDR_FLAGS = 8'd4;

    localparam logic [23:0] DEF_PER   = 24'd10000;
    localparam logic [15:0] DEF_P1WID = 16'd15;
    localparam logic [15:0] DEF_DEL   = 16'd100;
    localparam logic [15:0] DEF_P2WID = 16'd30;
    localparam logic        DEF_CP    = 1'b1;
    localparam logic        DEF_BL    = 1'b1;

    typedef enum logic [2:0] {
        P_IDLE, P_ADDR, P_D0, P_D1, P_D2, P_CHK
    } parser_state_t;

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_t;

endpackage

// File: rtl/pulse_param_rx_uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchronizer, falling-edge start detect, mid-bit sampling.
// byte_valid / stop_err are one-cycle strobes; byte_data holds the last assembled byte.
module uart_rx_byte
    import pulse_param_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       stop_err
);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;

    rx_state_t   state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]  bit_reg, bit_next;
    logic [7:0]  shift_reg, shift_next;
    logic        valid_reg, valid_next;
    logic        err_reg, err_next;
    logic        sync1_reg, sync2_reg, prev_reg;
    logic        fall;

    assign fall = prev_reg & ~sync2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RX_IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            prev_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
            sync1_reg <= rxd;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CW'(1);
        bit_next   = bit_reg;
        shift_next = shift_reg;
        valid_next = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                cnt_next = '0;
                if (fall) state_next = RX_START;
            end
            RX_START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (cnt_reg == CW'(HALF - 1)) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = sync2_reg ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_reg == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_next   = '0;
                    shift_next = {sync2_reg, shift_reg[7:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_reg == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_next   = '0;
                    state_next = RX_IDLE;
                    valid_next = sync2_reg;
                    err_next   = ~sync2_reg;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign byte_valid = valid_reg;
    assign byte_data  = shift_reg;
    assign stop_err   = err_reg;

endmodule

// File: rtl/pulse_param_rx.sv
// Host command receiver for the pulse generator: parses AA/ADDR/D0/D1/D2/CHK frames
// and atomically updates the selected parameter register.
module pulse_param_rx
    import pulse_param_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int TIMEOUT_CLKS = 24000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rxd,
    output logic [23:0] per,
    output logic [15:0] p1wid,
    output logic [15:0] del,
    output logic [15:0] p2wid,
    output logic        cp,
    output logic        bl,
    output logic        rx_done,
    output logic        frame_err
);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    logic [1:0] rst_sync_reg;
    logic       rst_n_int;

    // Assert asynchronously, release on clk so no flop sees a runt recovery edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_reg <= 2'b00;
        else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
    assign rst_n_int = rst_sync_reg[1];

    logic       byte_valid, stop_err;
    logic [7:0] byte_data;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n_int),
        .rxd        (rxd),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .stop_err   (stop_err)
    );

    parser_state_t state_reg, state_next;
    logic [7:0]    addr_reg, addr_next, d0_reg, d0_next, d1_reg, d1_next, d2_reg, d2_next;
    logic [TW-1:0] tmo_cnt_reg;
    logic          done_reg, done_next, err_reg, err_next, wr_en, tmo_hit;
    logic [23:0]   per_reg;
    logic [15:0]   p1wid_reg, del_reg, p2wid_reg;
    logic          cp_reg, bl_reg;

    assign tmo_hit = (state_reg != P_IDLE) && (tmo_cnt_reg == TW'(TIMEOUT_CLKS - 1));

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_reg   <= P_IDLE;
            addr_reg    <= '0;
            d0_reg      <= '0;
            d1_reg      <= '0;
            d2_reg      <= '0;
            tmo_cnt_reg <= '0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            d0_reg      <= d0_next;
            d1_reg      <= d1_next;
            d2_reg      <= d2_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            if (byte_valid || state_reg == P_IDLE) tmo_cnt_reg <= '0;
            else                                   tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
        end
    end

    // A byte arriving on the expiry cycle takes precedence over the timeout.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        d0_next    = d0_reg;
        d1_next    = d1_reg;
        d2_next    = d2_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        wr_en      = 1'b0;
        if (stop_err) begin
            state_next = P_IDLE;
            err_next   = 1'b1;
        end else if (byte_valid) begin
            case (state_reg)
                P_IDLE: if (byte_data == FRAME_HEADER) state_next = P_ADDR;
                P_ADDR: begin addr_next = byte_data; state_next = P_D0; end
                P_D0:   begin d0_next   = byte_data; state_next = P_D1; end
                P_D1:   begin d1_next   = byte_data; state_next = P_D2; end
                P_D2:   begin d2_next   = byte_data; state_next = P_CHK; end
                P_CHK: begin
                    state_next = P_IDLE;
                    if (byte_data == (addr_reg ^ d0_reg ^ d1_reg ^ d2_reg) && addr_reg <= ADDR_FLAGS) begin
                        wr_en     = 1'b1;
                        done_next = 1'b1;
                    end else begin
                        err_next  = 1'b1;
                    end
                end
                default: state_next = P_IDLE;
            endcase
        end else if (tmo_hit) begin
            state_next = P_IDLE;
            err_next   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            per_reg   <= DEF_PER;
            p1wid_reg <= DEF_P1WID;
            del_reg   <= DEF_DEL;
            p2wid_reg <= DEF_P2WID;
            cp_reg    <= DEF_CP;
            bl_reg    <= DEF_BL;
        end else if (wr_en) begin
            case (addr_reg)
                ADDR_PER:   per_reg   <= {d2_reg, d1_reg, d0_reg};
                ADDR_P1WID: p1wid_reg <= {d1_reg, d0_reg};
                ADDR_DEL:   del_reg   <= {d1_reg, d0_reg};
                ADDR_P2WID: p2wid_reg <= {d1_reg, d0_reg};
                ADDR_FLAGS: begin cp_reg <= d0_reg[0]; bl_reg <= d0_reg[1]; end
                default: ;
            endcase
        end
    end

    assign per       = per_reg;
    assign p1wid     = p1wid_reg;
    assign del       = del_reg;
    assign p2wid     = p2wid_reg;
    assign cp        = cp_reg;
    assign bl        = bl_reg;
    assign rx_done   = done_reg;
    assign frame_err = err_reg;

endmodule

// File: tb/tb_pulse_param_rx.sv
// Bench for pulse_param_rx: frame table plus hand-written corner sequences,
// expected strobes/register values queued at send time and checked on each strobe.
module tb_pulse_param_rx;
    localparam int CPB = 16;
    localparam int TMO = 3000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rxd;
    logic [23:0] per;
    logic [15:0] p1wid, del, p2wid;
    logic        cp, bl, rx_done, frame_err;

    pulse_param_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .rxd(rxd),
        .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid),
        .cp(cp), .bl(bl), .rx_done(rx_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        done;
        logic [23:0] per;
        logic [15:0] p1wid, del, p2wid;
        logic        cp, bl;
    } exp_t;

    typedef struct {
        logic [47:0] frame;
        exp_t        e;
    } vec_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic chk_regs(input string tag, input exp_t e);
        chk({tag, ".per"},   per,   e.per);
        chk({tag, ".p1wid"}, {8'd0, p1wid}, {8'd0, e.p1wid});
        chk({tag, ".del"},   {8'd0, del},   {8'd0, e.del});
        chk({tag, ".p2wid"}, {8'd0, p2wid}, {8'd0, e.p2wid});
        chk({tag, ".cp"},    {23'd0, cp},   {23'd0, e.cp});
        chk({tag, ".bl"},    {23'd0, bl},   {23'd0, e.bl});
    endtask

    always @(negedge clk) begin
        if (rx_done || frame_err) begin
            exp_t e;
            done_cyc = cyc;
            chk("strobe_exclusive", {23'd0, rx_done & frame_err}, 24'd0);
            if (q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_strobe: got rx_done=%0b frame_err=%0b expected none", rx_done, frame_err);
            end else begin
                e = q.pop_front();
                chk("strobe_kind_done", {23'd0, rx_done}, {23'd0, e.done});
                chk_regs("strobe", e);
            end
        end
    end

    // Called on a negedge and returns on a negedge, so consecutive bytes have zero gap.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        start_cyc = cyc + 1;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic send_frame(input logic [47:0] f);
        for (int i = 0; i < 6; i++) send_byte(f[47 - 8*i -: 8], 1'b1);
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
        chk({name, ".pending"}, 24'(q.size()), 24'd0);
        q.delete();
    endtask

    function automatic exp_t mk(input logic d, input logic [23:0] pr, input logic [15:0] w1,
                                input logic [15:0] dl, input logic [15:0] w2, input logic c, input logic b);
        exp_t e;
        e.done = d; e.per = pr; e.p1wid = w1; e.del = dl; e.p2wid = w2; e.cp = c; e.bl = b;
        return e;
    endfunction

    vec_t vecs [9];
    exp_t dflt;

    initial begin
        dflt = mk(1'b0, 24'd10000, 16'd15, 16'd100, 16'd30, 1'b1, 1'b1);
        vecs[0] = '{48'hAA_00_40_42_0F_0D, mk(1, 24'h0F4240, 15, 100, 30, 1, 1)};
        vecs[1] = '{48'hAA_04_02_00_00_06, mk(1, 24'h0F4240, 15, 100, 30, 0, 1)};
        vecs[2] = '{48'hAA_01_20_00_00_21, mk(1, 24'h0F4240, 32, 100, 30, 0, 1)};
        vecs[3] = '{48'hAA_02_64_00_00_00, mk(0, 24'h0F4240, 32, 100, 30, 0, 1)};
        vecs[4] = '{48'hAA_07_01_00_00_06, mk(0, 24'h0F4240, 32, 100, 30, 0, 1)};
        vecs[5] = '{48'hAA_03_AA_00_00_A9, mk(1, 24'h0F4240, 32, 100, 16'h00AA, 0, 1)};
        vecs[6] = '{48'hAA_02_34_12_99_BD, mk(1, 24'h0F4240, 32, 16'h1234, 16'h00AA, 0, 1)};
        vecs[7] = '{48'hAA_04_FF_FF_FF_FB, mk(1, 24'h0F4240, 32, 16'h1234, 16'h00AA, 1, 1)};
        vecs[8] = '{48'hAA_00_FF_FF_FF_FF, mk(1, 24'hFFFFFF, 32, 16'h1234, 16'h00AA, 1, 1)};

        rxd = 1'b1;
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        chk_regs("reset", dflt);
        chk("reset.rx_done",   {23'd0, rx_done},   24'd0);
        chk("reset.frame_err", {23'd0, frame_err}, 24'd0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            q.push_back(vecs[i].e);
            send_frame(vecs[i].frame);
            drain($sformatf("vec%0d", i), 200);
            if (i == 0) chk("latency", 24'(done_cyc - start_cyc), 24'(2 + CPB/2 + 9*CPB + 1));
        end

        // Bad stop bit on D1: frame rejected, trailing D2/CHK dropped in idle.
        q.push_back(mk(0, 24'hFFFFFF, 32, 16'h1234, 16'h00AA, 1, 1));
        send_byte(8'hAA, 1); send_byte(8'h01, 1); send_byte(8'h05, 1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1); send_byte(8'h04, 1);
        drain("stop_err", 200);

        // Mid-frame stall beyond the timeout; remaining bytes must not update p2wid.
        q.push_back(mk(0, 24'hFFFFFF, 32, 16'h1234, 16'h00AA, 1, 1));
        send_byte(8'hAA, 1); send_byte(8'h03, 1); send_byte(8'h1E, 1);
        repeat (TMO + 1000) @(negedge clk);
        drain("timeout", 1);
        send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h1D, 1);
        repeat (50) @(negedge clk);
        chk("timeout.p2wid", {8'd0, p2wid}, 24'h0000AA);

        // Short low glitch after the header must not be taken as the ADDR byte.
        q.push_back(mk(1, 24'hFFFFFF, 5, 16'h1234, 16'h00AA, 1, 1));
        send_byte(8'hAA, 1);
        rxd = 1'b0;
        repeat (CPB/2 - 3) @(negedge clk);
        rxd = 1'b1;
        repeat (CPB * 12) @(negedge clk);
        send_byte(8'h01, 1); send_byte(8'h05, 1); send_byte(8'h00, 1);
        send_byte(8'h00, 1); send_byte(8'h04, 1);
        drain("glitch", 200);

        // Reset during D0, then a garbage byte and a full frame after release.
        send_byte(8'hAA, 1); send_byte(8'h00, 1);
        rxd = 1'b0;
        repeat (CPB * 3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_regs("midreset", dflt);
        rxd = 1'b1;
        @(negedge clk);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        q.push_back(mk(1, 24'd10000, 15, 16'd200, 30, 1, 1));
        send_byte(8'h55, 1);
        send_frame(48'hAA_02_C8_00_00_CA);
        drain("after_reset", 200);

        repeat (20) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pulse_param_rx.md
# pulse_param_rx

UART command receiver that loads the pulse-sequence parameters (period, pulse widths, delay, CPMG/CW select, blocking enable) from a host over the serial line. Runs on the 12 MHz board clock and drives the `per`, `p1wid`, `del`, `p2wid`, `cp`, `bl` inputs of the pulse generator, replacing its hard-coded values. A one-cycle `rx_done` strobe marks each accepted update.

## Interface
- `CLKS_PER_BIT`, 104: clk cycles per UART bit (12 MHz / 115200 baud).
- `TIMEOUT_CLKS`, 24000: max idle clk cycles between bytes inside a frame (2 ms).
- `clk  input  1  12 MHz system clock`
- `reset_n  input  1  asynchronous, active-low reset`
- `rxd  input  1  UART serial in, 8N1, idle high, asynchronous to clk`
- `per  output  24  pulse period, reset 10000`
- `p1wid  output  16  first pulse width, reset 15`
- `del  output  16  inter-pulse delay, reset 100`
- `p2wid  output  16  second pulse width, reset 30`
- `cp  output  1  0 = CW, 1 = pulsed/CPMG, reset 1`
- `bl  output  1  blocking enable, reset 1`
- `rx_done  output  1  one-cycle strobe on register update, reset 0`
- `frame_err  output  1  one-cycle strobe on rejected frame or bad stop bit, reset 0`

## Operation
- Frame: 6 bytes = 0xAA header, ADDR, D0, D1, D2 (24-bit little-endian), CHK = ADDR ^ D0 ^ D1 ^ D2.
- ADDR map: 0 → per = {D2,D1,D0}; 1 → p1wid = {D1,D0}; 2 → del; 3 → p2wid; 4 → cp = D0[0], bl = D0[1]. 16-bit targets ignore D2; flags ignore all other bits. D2 is always transmitted.
- Byte layer: `rxd` through 2-FF synchronizer; falling edge starts; sample at CLKS_PER_BIT/2; if high, false start → back to idle, no byte. Then 8 data bits LSB-first at CLKS_PER_BIT spacing, then stop bit. Stop = 1 → `byte_valid` strobe with data; stop = 0 → no byte, `frame_err` strobe, parser forced to IDLE.
- Parser FSM: IDLE → (byte == 0xAA) ADDR → D0 → D1 → D2 → CHK → IDLE. In IDLE, non-0xAA bytes are dropped silently. On CHK: if checksum matches and ADDR ≤ 4 → write target register, pulse `rx_done`; otherwise → no write, pulse `frame_err`.
- Timeout: counter cleared on every `byte_valid`; counts while parser ≠ IDLE; reaching TIMEOUT_CLKS → IDLE, `frame_err` pulse, partial frame discarded.
- Outputs hold last accepted values indefinitely; no partial update ever visible (all target bits written on one edge).

## Timing
- Byte latency: `byte_valid` asserted 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the first clk edge sampling `rxd` low (sync included).
- Register update and `rx_done` on the edge after CHK `byte_valid` (1-cycle latency); both outputs registered.
- `rx_done` and `frame_err` never both high in one cycle.
- `byte_valid` coincident with timeout expiry: byte wins, counter clears, no timeout.
- 0xAA received in ADDR..CHK states is treated as data, not a resync.
- `reset_n` low mid-frame: all outputs to reset values immediately, FSMs to IDLE; a byte in flight is lost; reception resumes on next falling edge after release (release synchronized internally).
- Back-to-back frames with zero gap between stop and next start are accepted.

## Structure
- Shared package: frame header constant 0xAA, ADDR codes (PER, P1WID, DEL, P2WID, FLAGS), parser state enum, reset default values (also used by the pulse generator's bench).
- One sub-module: `uart_rx_byte` (synchronizer, bit timing, `byte_valid`/`byte_data`/`stop_err`); the parser, timeout and register file live in the top.

## Test plan
- Reset: hold `reset_n` low → per=10000, p1wid=15, del=100, p2wid=30, cp=1, bl=1, strobes 0.
- Frame AA 00 40 42 0F 0D → per = 0x0F4240 (1000000), one `rx_done` pulse one cycle after final stop sample.
- Frame AA 04 02 00 00 06 → cp=0, bl=1; then AA 01 20 00 00 21 → p1wid=32, cp/bl unchanged.
- Bad checksum AA 02 64 00 00 00 → del stays 100, one `frame_err`, no `rx_done`; bad ADDR 07 with valid CHK → same.
- Send AA 03 1E, stall 25000 cycles, then 00 00 1D → `frame_err` at timeout, p2wid unchanged; trailing bytes dropped in IDLE.
- Stop bit forced 0 on D1 byte → `frame_err`, parser IDLE; glitch low shorter than CLKS_PER_BIT/2 → no byte; `reset_n` asserted mid-D0 → defaults restored, next full frame accepted.
